// File: rtl/dmi_tl_pkg.sv
// rtl/dmi_tl_pkg.sv - shared encodings, FSM state and handshake flag helpers for the DMI to TL bridge
package dmi_tl_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;
    localparam int TO_CNT_W   = 10;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;
    localparam logic [1:0] DMI_OP_RSVD  = 2'd3;

    localparam logic [1:0] DMI_RESP_OK     = 2'd0;
    localparam logic [1:0] DMI_RESP_FAILED = 2'd2;
    localparam logic [1:0] DMI_RESP_BUSY   = 2'd3;

    localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_A_GET             = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_D,
        ST_RESP
    } bridge_state_e;

    typedef struct packed {
        logic req_ready;
        logic a_valid;
        logic d_ready;
        logic resp_valid;
    } hs_flags_t;

    // Handshake outputs are a pure function of the state being entered, so they can be registered with it.
    function automatic hs_flags_t flags_for(input bridge_state_e s);
        hs_flags_t f;
        f.req_ready  = (s == ST_IDLE);
        f.a_valid    = (s == ST_ISSUE);
        f.d_ready    = (s != ST_RESP);
        f.resp_valid = (s == ST_RESP);
        return f;
    endfunction

    function automatic logic [2:0] expected_d_opcode(input logic is_read);
        return is_read ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
    endfunction

endpackage

// File: rtl/dmi_tl_timeout_counter.sv
// rtl/dmi_tl_timeout_counter.sv - saturating wait counter that flags when the D-channel wait has run out
module dmi_tl_timeout_counter
    import dmi_tl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_CNT_W-1:0] LAST_COUNT = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_W-1:0] count;

    // Saturates at the last count so a stalled state can never wrap back into a live window.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST_COUNT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/dmi_tl_bridge.sv
// rtl/dmi_tl_bridge.sv - single-outstanding DMI request to TileLink-UL A/D channel bridge
module dmi_tl_bridge
    import dmi_tl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dmi_req_valid,
    output logic                  dmi_req_ready,
    input  logic [1:0]            dmi_req_op,
    input  logic [DMI_ADDR_W-1:0] dmi_req_addr,
    input  logic [DMI_DATA_W-1:0] dmi_req_data,
    output logic                  dmi_resp_valid,
    input  logic                  dmi_resp_ready,
    output logic [DMI_DATA_W-1:0] dmi_resp_data,
    output logic [1:0]            dmi_resp_resp,
    output logic                  tl_a_valid,
    input  logic                  tl_a_ready,
    output logic [2:0]            tl_a_opcode,
    output logic [DMI_ADDR_W-1:0] tl_a_address,
    output logic [DMI_DATA_W-1:0] tl_a_data,
    output logic [3:0]            tl_a_mask,
    input  logic                  tl_d_valid,
    output logic                  tl_d_ready,
    input  logic [2:0]            tl_d_opcode,
    input  logic [DMI_DATA_W-1:0] tl_d_data,
    input  logic                  tl_d_denied
);

    bridge_state_e         state;
    hs_flags_t             flags_q;
    logic [1:0]            op_q;
    logic [DMI_ADDR_W-1:0] addr_q;
    logic [DMI_DATA_W-1:0] wdata_q;
    logic [DMI_DATA_W-1:0] rdata_q;
    logic [1:0]            resp_q;

    logic                  req_fire;
    logic                  a_fire;
    logic                  d_fire;
    logic                  is_read;
    logic                  d_ok;
    logic [DMI_DATA_W-1:0] d_resp_data;
    logic [1:0]            d_resp_code;
    logic                  wait_expired;

    assign dmi_req_ready  = flags_q.req_ready;
    assign tl_a_valid     = flags_q.a_valid;
    assign tl_d_ready     = flags_q.d_ready;
    assign dmi_resp_valid = flags_q.resp_valid;

    assign req_fire = dmi_req_valid && dmi_req_ready;
    assign a_fire   = tl_a_valid && tl_a_ready;
    assign d_fire   = tl_d_valid && tl_d_ready;

    // A-channel fields come only from the captured request.
    assign is_read      = (op_q == DMI_OP_READ);
    assign tl_a_opcode  = is_read ? TL_A_GET : TL_A_PUT_FULL;
    assign tl_a_address = addr_q;
    assign tl_a_data    = wdata_q;
    assign tl_a_mask    = 4'hF;

    // A denied beat or an ack of the wrong kind fails the access and never leaks data.
    assign d_ok        = !tl_d_denied && (tl_d_opcode == expected_d_opcode(is_read));
    assign d_resp_code = d_ok ? DMI_RESP_OK : DMI_RESP_FAILED;
    assign d_resp_data = (d_ok && is_read) ? tl_d_data : '0;

    assign dmi_resp_data = rdata_q;
    assign dmi_resp_resp = resp_q;

    dmi_tl_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (a_fire),
        .enable (state == ST_WAIT_D),
        .expired(wait_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            flags_q <= flags_for(ST_IDLE);
            op_q    <= DMI_OP_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= DMI_RESP_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_fire) begin
                        op_q    <= dmi_req_op;
                        addr_q  <= dmi_req_addr;
                        wdata_q <= (dmi_req_op == DMI_OP_WRITE) ? dmi_req_data : '0;
                        case (dmi_req_op)
                            DMI_OP_READ, DMI_OP_WRITE: begin
                                state   <= ST_ISSUE;
                                flags_q <= flags_for(ST_ISSUE);
                            end
                            DMI_OP_NOP: begin
                                rdata_q <= '0;
                                resp_q  <= DMI_RESP_OK;
                                state   <= ST_RESP;
                                flags_q <= flags_for(ST_RESP);
                            end
                            default: begin
                                rdata_q <= '0;
                                resp_q  <= DMI_RESP_FAILED;
                                state   <= ST_RESP;
                                flags_q <= flags_for(ST_RESP);
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    // A D beat before our A has gone out cannot belong to us and is dropped.
                    if (a_fire) begin
                        if (d_fire) begin
                            rdata_q <= d_resp_data;
                            resp_q  <= d_resp_code;
                            state   <= ST_RESP;
                            flags_q <= flags_for(ST_RESP);
                        end else begin
                            state   <= ST_WAIT_D;
                            flags_q <= flags_for(ST_WAIT_D);
                        end
                    end
                end
                ST_WAIT_D: begin
                    if (d_fire) begin
                        rdata_q <= d_resp_data;
                        resp_q  <= d_resp_code;
                        state   <= ST_RESP;
                        flags_q <= flags_for(ST_RESP);
                    end else if (wait_expired) begin
                        rdata_q <= '0;
                        resp_q  <= DMI_RESP_BUSY;
                        state   <= ST_RESP;
                        flags_q <= flags_for(ST_RESP);
                    end
                end
                ST_RESP: begin
                    if (dmi_resp_ready) begin
                        state   <= ST_IDLE;
                        flags_q <= flags_for(ST_IDLE);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    flags_q <= flags_for(ST_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_tl_bridge.sv
// tb/tb_dmi_tl_bridge.sv - randomized self-checking bench for dmi_tl_bridge against a transaction-level model
module tb_dmi_tl_bridge;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dmi_req_valid, dmi_req_ready;
    logic [1:0]  dmi_req_op;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic        dmi_resp_valid, dmi_resp_ready;
    logic [31:0] dmi_resp_data;
    logic [1:0]  dmi_resp_resp;
    logic        tl_a_valid, tl_a_ready;
    logic [2:0]  tl_a_opcode;
    logic [6:0]  tl_a_address;
    logic [31:0] tl_a_data;
    logic [3:0]  tl_a_mask;
    logic        tl_d_valid, tl_d_ready;
    logic [2:0]  tl_d_opcode;
    logic [31:0] tl_d_data;
    logic        tl_d_denied;

    always #5 clock = ~clock;

    dmi_tl_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_op(dmi_req_op), .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data),
        .dmi_resp_valid(dmi_resp_valid), .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp_data(dmi_resp_data), .dmi_resp_resp(dmi_resp_resp),
        .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
        .tl_a_address(tl_a_address), .tl_a_data(tl_a_data), .tl_a_mask(tl_a_mask),
        .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
        .tl_d_data(tl_d_data), .tl_d_denied(tl_d_denied)
    );

    // ad: cycles A is held off; dd: D delay after A fire (0 same cycle, > TO never sent)
    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] wdata;
        int          ad;
        int          dd;
        bit          denied;
        bit          badop;
        logic [31:0] rdata;
        bit          stray;
        int          rr;
        bit          late;
    } txn_t;

    txn_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          fire_cyc = 0;
    bit          prev_pend = 0;
    bit          prev_av = 0;
    logic [31:0] prev_data;
    logic [1:0]  prev_resp;
    bit          have;
    txn_t        h;
    logic [31:0] last_data;
    logic [1:0]  last_resp;
    int          last_lat;
    logic [2:0]  last_a_opcode;
    logic [31:0] last_a_data;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] model_resp(input txn_t t);
        if (t.op == 2'd0) return 2'd0;
        if (t.op == 2'd3) return 2'd2;
        if (t.dd > TO) return 2'd3;
        if (t.denied || t.badop) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] model_data(input txn_t t);
        if (t.op == 2'd1 && t.dd <= TO && !t.denied && !t.badop) return t.rdata;
        return 32'd0;
    endfunction

    // Cycles from request fire to the first cycle of dmi_resp_valid.
    function automatic int model_lat(input txn_t t);
        if (t.op == 2'd0 || t.op == 2'd3) return 1;
        if (t.dd == 0) return t.ad + 2;
        if (t.dd <= TO) return t.ad + 2 + t.dd;
        return t.ad + 2 + TO;
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            prev_pend = 0;
            prev_av   = 0;
        end else begin
            have = (exp_q.size() != 0);
            if (have) h = exp_q[0];
            check("mask", {28'd0, tl_a_mask}, 32'hF);
            check("d_ready_vs_resp", tl_d_ready, !dmi_resp_valid);
            check("req_ready_exclusive", dmi_req_ready && (tl_a_valid || dmi_resp_valid), 0);
            if (dmi_req_valid && dmi_req_ready) fire_cyc = cyc;
            if (tl_a_valid) begin
                check("a_valid_expected", have && (h.op == 2'd1 || h.op == 2'd2), 1);
                if (have) begin
                    if (!prev_av) check("a_valid_latency", cyc - fire_cyc, 1);
                    if (tl_a_ready) begin
                        check("a_opcode", tl_a_opcode, (h.op == 2'd1) ? 32'd4 : 32'd0);
                        check("a_address", tl_a_address, h.addr);
                        check("a_data", tl_a_data, (h.op == 2'd2) ? h.wdata : 32'd0);
                        check("a_fire_latency", cyc - fire_cyc, 1 + h.ad);
                        last_a_opcode = tl_a_opcode;
                        last_a_data   = tl_a_data;
                    end
                end
            end
            if (dmi_resp_valid) begin
                check("resp_expected", have, 1);
                if (have) begin
                    if (!prev_pend) begin
                        last_lat = cyc - fire_cyc;
                        check("resp_latency", last_lat, model_lat(h));
                    end else begin
                        check("resp_data_stable", dmi_resp_data, prev_data);
                        check("resp_code_stable", dmi_resp_resp, prev_resp);
                    end
                    if (dmi_resp_ready) begin
                        check("resp_data", dmi_resp_data, model_data(h));
                        check("resp_code", dmi_resp_resp, model_resp(h));
                        last_data = dmi_resp_data;
                        last_resp = dmi_resp_resp;
                        exp_q.delete(0);
                    end
                end
            end else if (prev_pend) begin
                check("resp_valid_held", dmi_resp_valid, 1);
            end
            prev_pend = dmi_resp_valid && !dmi_resp_ready;
            prev_data = dmi_resp_data;
            prev_resp = dmi_resp_resp;
            prev_av   = tl_a_valid;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic txn_t mk(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                                input int ad, input int dd, input bit denied, input bit badop,
                                input logic [31:0] rdata, input int rr, input bit late);
        txn_t t;
        t.op = op; t.addr = addr; t.wdata = wdata; t.ad = ad; t.dd = dd;
        t.denied = denied; t.badop = badop; t.rdata = rdata; t.stray = 0; t.rr = rr; t.late = late;
        return t;
    endfunction

    task automatic drive_d(input txn_t t);
        tl_d_valid  = 1'b1;
        tl_d_denied = t.denied;
        tl_d_opcode = ((t.op == 2'd1) != t.badop) ? 3'd1 : 3'd0;
        tl_d_data   = t.rdata;
    endtask

    task automatic run_txn(input txn_t t);
        int n;
        exp_q.push_back(t);
        dmi_req_valid = 1'b1;
        dmi_req_op    = t.op;
        dmi_req_addr  = t.addr;
        dmi_req_data  = t.wdata;
        n = 0;
        while (!dmi_req_ready && n < 20) begin step(); n++; end
        check("req_accepted", dmi_req_ready, 1);
        step();
        dmi_req_valid = 1'b0;
        if (t.op == 2'd1 || t.op == 2'd2) begin
            for (int k = 0; k < t.ad; k++) begin
                tl_a_ready = 1'b0;
                if (t.stray && k == 0) begin
                    tl_d_valid  = 1'b1;
                    tl_d_denied = 1'b0;
                    tl_d_opcode = 3'($urandom_range(0, 1));
                    tl_d_data   = $urandom;
                end
                step();
                tl_d_valid = 1'b0;
            end
            tl_a_ready = 1'b1;
            if (t.dd == 0) drive_d(t);
            step();
            tl_a_ready = 1'b0;
            tl_d_valid = 1'b0;
            if (t.dd > 0 && t.dd <= TO) begin
                repeat (t.dd - 1) step();
                drive_d(t);
                step();
                tl_d_valid = 1'b0;
            end
        end
        n = 0;
        while (!dmi_resp_valid && n < 40) begin step(); n++; end
        check("resp_arrived", dmi_resp_valid, 1);
        if (!dmi_resp_valid) exp_q.delete();
        repeat (t.rr) step();
        dmi_resp_ready = 1'b1;
        step();
        dmi_resp_ready = 1'b0;
        if (t.dd > TO && t.late && (t.op == 2'd1 || t.op == 2'd2)) begin
            tl_d_valid  = 1'b1;
            tl_d_denied = 1'b0;
            tl_d_opcode = (t.op == 2'd1) ? 3'd1 : 3'd0;
            tl_d_data   = $urandom;
            step();
            tl_d_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  dmi_req_ready, 1);
        check({tag, "_resp_valid"}, dmi_resp_valid, 0);
        check({tag, "_a_valid"},    tl_a_valid, 0);
        check({tag, "_d_ready"},    tl_d_ready, 1);
        check({tag, "_resp_data"},  dmi_resp_data, 0);
        check({tag, "_resp_code"},  dmi_resp_resp, 0);
        check({tag, "_a_opcode"},   tl_a_opcode, 0);
        check({tag, "_a_address"},  tl_a_address, 0);
        check({tag, "_a_data"},     tl_a_data, 0);
        check({tag, "_a_mask"},     tl_a_mask, 32'hF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int   r;
        dmi_req_valid = 0; dmi_req_op = 0; dmi_req_addr = 0; dmi_req_data = 0;
        dmi_resp_ready = 0; tl_a_ready = 0; tl_d_valid = 0; tl_d_opcode = 0;
        tl_d_data = 0; tl_d_denied = 0;
        reset = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset_hold");
        reset = 1'b0;
        check_reset_outputs("reset_release");
        step();
        check_reset_outputs("first_idle");

        run_txn(mk(2'd1, 7'h10, 32'd0, 0, 0, 0, 0, 32'h00118380, 0, 0));
        check("lit_read_data", last_data, 32'h00118380);
        check("lit_read_code", last_resp, 0);
        check("lit_read_lat", last_lat, 2);
        check("lit_read_a_opcode", last_a_opcode, 4);

        run_txn(mk(2'd2, 7'h10, 32'h80000001, 0, 3, 0, 0, 32'h5555AAAA, 0, 0));
        check("lit_write_a_opcode", last_a_opcode, 0);
        check("lit_write_a_data", last_a_data, 32'h80000001);
        check("lit_write_data", last_data, 0);
        check("lit_write_code", last_resp, 0);
        check("lit_write_lat", last_lat, 5);

        run_txn(mk(2'd3, 7'h22, 32'h1234, 0, 0, 0, 0, 32'd0, 0, 0));
        check("lit_rsvd_code", last_resp, 2);
        check("lit_rsvd_lat", last_lat, 1);

        run_txn(mk(2'd0, 7'h01, 32'h0, 0, 0, 0, 0, 32'd0, 0, 0));
        check("lit_nop_code", last_resp, 0);
        check("lit_nop_lat", last_lat, 1);

        run_txn(mk(2'd1, 7'h11, 32'd0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0));
        check("lit_denied_data", last_data, 0);
        check("lit_denied_code", last_resp, 2);

        run_txn(mk(2'd2, 7'h12, 32'h5, 1, 2, 0, 1, 32'h0, 1, 0));
        check("lit_badop_code", last_resp, 2);

        run_txn(mk(2'd1, 7'h05, 32'd0, 0, TO + 1, 0, 0, 32'h11111111, 0, 1));
        check("lit_timeout_code", last_resp, 3);
        check("lit_timeout_data", last_data, 0);
        check("lit_timeout_lat", last_lat, 6);
        run_txn(mk(2'd1, 7'h06, 32'd0, 0, 1, 0, 0, 32'hCAFE0001, 0, 0));
        check("lit_after_late_data", last_data, 32'hCAFE0001);

        run_txn(mk(2'd1, 7'h07, 32'd0, 0, 0, 0, 0, 32'h0BADF00D, 5, 0));
        check("lit_backpressure_data", last_data, 32'h0BADF00D);

        t = mk(2'd1, 7'h0A, 32'd0, 0, TO + 1, 0, 0, 32'd0, 0, 0);
        exp_q.push_back(t);
        dmi_req_valid = 1'b1; dmi_req_op = t.op; dmi_req_addr = t.addr; dmi_req_data = 0;
        step();
        dmi_req_valid = 1'b0;
        tl_a_ready = 1'b1;
        step();
        tl_a_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        check_reset_outputs("reset_mid");
        reset = 1'b0;
        check_reset_outputs("reset_mid_release");
        step();
        check_reset_outputs("reset_mid_idle");
        repeat (12) step();
        check("no_spurious_resp", dmi_resp_valid, 0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            t.op     = (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : (r < 8) ? 2'd0 : 2'd3;
            t.addr   = 7'($urandom);
            t.wdata  = $urandom;
            t.ad     = $urandom_range(0, 2);
            t.dd     = $urandom_range(0, TO + 1);
            t.denied = ($urandom_range(0, 7) == 0);
            t.badop  = ($urandom_range(0, 7) == 0);
            t.rdata  = $urandom;
            t.stray  = ($urandom_range(0, 3) == 0);
            t.rr     = $urandom_range(0, 3);
            t.late   = ($urandom_range(0, 1) == 1);
            run_txn(t);
            if ($urandom_range(0, 3) == 0) step();
        end

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
